// File: rtl/divu_seq_pkg.sv
// -----------------------------------------------------------------------------
// divu_seq_pkg
//   Shared CPU definitions for the sequential unsigned divider.
//   Holds the divider FSM state encoding, the datapath width, the iteration
//   count and the derived counter width and reload value.
// -----------------------------------------------------------------------------
package divu_seq_pkg;

    // Datapath width of the divider (operands and results).
    localparam int DIV_WIDTH = 32;

    // One restoring step per dividend bit.
    localparam int DIV_ITERS = 32;

    // Iteration counter width and the value loaded when a division starts.
    // The counter runs from DIV_ITERS-1 down to 0, so it gives exactly
    // DIV_ITERS RUN cycles.
    localparam int                CNT_W    = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

    // Divider FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage : divu_seq_pkg

// File: rtl/divu_seq_sltu32.sv
// -----------------------------------------------------------------------------
// sltu32
//   32-bit unsigned set-less-than. result = {31'b0, (a <u b)}.
//   All 32 bits are treated as magnitude; there is no sign interpretation.
//
// Ports
//   a      : in  32  left operand
//   b      : in  32  right operand
//   result : out 32  bit 0 = 1 when a < b (unsigned), upper bits always 0
// -----------------------------------------------------------------------------
module sltu32
    import divu_seq_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] a,
    input  logic [DIV_WIDTH-1:0] b,
    output logic [DIV_WIDTH-1:0] result
);

    // Borrow chain of a - b, LSB first. The final borrow out is set exactly
    // when b is larger than a as an unsigned number.
    logic [DIV_WIDTH:0] borrow;

    assign borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < DIV_WIDTH; gi++) begin : g_borrow
            // Borrow is generated when a=0,b=1 and propagated when the bits
            // are equal.
            assign borrow[gi+1] = (~a[gi] & b[gi])
                                | (~(a[gi] ^ b[gi]) & borrow[gi]);
        end
    endgenerate

    assign result = {{(DIV_WIDTH-1){1'b0}}, borrow[DIV_WIDTH]};

endmodule : sltu32

// File: rtl/divu_seq.sv
// -----------------------------------------------------------------------------
// divu_seq
//   Sequential 32-bit unsigned divider (MIPS DIVU style), restoring algorithm.
//   One quotient bit is produced per clock, MSB first. A division takes
//   exactly 32 RUN cycles followed by a single DONE cycle.
//
// Ports
//   clk         : in   1  clock, rising edge
//   rst_n       : in   1  synchronous active-low reset
//   start       : in   1  request a division; only looked at in IDLE
//   dividend    : in  32  unsigned dividend, captured on an accepted start
//   divisor     : in  32  unsigned divisor, captured on an accepted start
//   flush       : in   1  abort any operation; return to IDLE with no done
//   busy        : out  1  high while in RUN or DONE
//   done        : out  1  one-cycle pulse when results are valid
//   quotient    : out 32  LO result
//   remainder   : out 32  HI result
//   div_by_zero : out  1  captured divisor was zero (set together with done)
//
// Priority at a clock edge: reset, then flush, then normal FSM operation.
// The result registers only change on the edge that enters DONE, so a flush
// or reset-free abort leaves the previous results visible.
// -----------------------------------------------------------------------------
module divu_seq
    import divu_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    div_state_e           state_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [DIV_WIDTH-1:0] dvd_reg;        // dividend, shifted left each step
    logic [DIV_WIDTH-1:0] dsr_reg;        // captured divisor
    logic [DIV_WIDTH-1:0] rem_reg;        // partial remainder accumulator
    logic [DIV_WIDTH-1:0] quo_reg;        // quotient bits collected so far

    logic                 busy_reg;
    logic                 done_reg;
    logic [DIV_WIDTH-1:0] quotient_reg;
    logic [DIV_WIDTH-1:0] remainder_reg;
    logic                 dbz_reg;

    // -------------------------------------------------------------------------
    // One restoring step
    // -------------------------------------------------------------------------
    logic                 carry;
    logic [DIV_WIDTH-1:0] shifted;
    logic [DIV_WIDTH-1:0] slt_result;
    logic [DIV_WIDTH-2:0] slt_unused;
    logic                 ge;
    logic [DIV_WIDTH-1:0] rem_next;
    logic [DIV_WIDTH-1:0] quo_next;

    // Bring the next dividend bit into the partial remainder. The bit that
    // falls off the top is the 33rd bit of the shifted value; when it is set
    // the shifted value is certainly >= divisor, whatever the low 32 bits say.
    assign carry   = rem_reg[DIV_WIDTH-1];
    assign shifted = {rem_reg[DIV_WIDTH-2:0], dvd_reg[DIV_WIDTH-1]};

    sltu32 u_cmp (
        .a      (shifted),
        .b      (dsr_reg),
        .result (slt_result)
    );

    // Only bit 0 of the comparator carries information.
    assign slt_unused = slt_result[DIV_WIDTH-1:1];

    assign ge = carry | ~slt_result[0];

    // With carry set the true 33-bit difference fits in 32 bits, so the
    // wrap-around 32-bit subtraction gives the right remainder.
    assign rem_next = ge ? (shifted - dsr_reg) : shifted;
    assign quo_next = {quo_reg[DIV_WIDTH-2:0], ge};

    // -------------------------------------------------------------------------
    // FSM and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            dvd_reg       <= '0;
            dsr_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else if (flush) begin
            // Abort: results are deliberately left untouched.
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b1;
                        dvd_reg   <= dividend;
                        dsr_reg   <= divisor;
                        rem_reg   <= '0;
                        quo_reg   <= '0;
                        count_reg <= CNT_LAST;
                    end
                end

                ST_RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    dvd_reg <= {dvd_reg[DIV_WIDTH-2:0], 1'b0};
                    if (count_reg == '0) begin
                        // Last step: publish the results from this step's
                        // values directly, they are not in rem/quo yet.
                        state_reg     <= ST_DONE;
                        done_reg      <= 1'b1;
                        quotient_reg  <= quo_next;
                        remainder_reg <= rem_next;
                        dbz_reg       <= (dsr_reg == '0);
                    end else begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all registered)
    // -------------------------------------------------------------------------
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule : divu_seq
